btn_conditioner: RTL and testbench

//   Parametrised N-channel front end for board push-buttons and switches.
//   Per channel: input synchroniser, debounce counter, then a clean level plus
//   one-cycle rise/fall pulses. Optional auto-repeat pulses while a button is held.

---
 rtl/btn_conditioner_if.sv | 28 ++
 rtl/btn_conditioner.sv | 155 +++++++++++++++
 tb/tb_btn_conditioner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner bundle: raw pin inputs in, debounced level and pulses out.
// The slave modport is the conditioner. The master modport is whatever drives
// the pins and consumes the clean signals.
interface btn_conditioner_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_repeat
    );
endinterface

// File: rtl/btn_conditioner.sv
// N-channel push-button / switch conditioner.
// Each channel has the following stages, in order:
//   1. A synchroniser.
//   2. A debounce counter.
//   3. A clean level, plus one-cycle rise and fall pulses.
// Optional feature macro BTN_REPEAT_EN adds auto-repeat pulses while a channel
// is held high. Without the macro, btn_repeat is tied low. The port list is
// the same in both builds.
// Reset is asynchronous and active-low (rst).
module btn_conditioner #(
    parameter int   N_CH          = 2,
    parameter int   DB_CYCLES     = 250000,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   REPEAT_DELAY  = 25000000,
    parameter int   REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);
    // The debounce counter only needs to reach DB_CYCLES-1.
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef BTN_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
`endif

    // Out-of-range parameters show up as this named scope in the elaborated hierarchy.
    if (!(DB_CYCLES >= 1 && SYNC_STAGES >= 2 && REPEAT_DELAY >= 1 && REPEAT_PERIOD >= 1))
    begin : g_bad_params_unsupported
    end

    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] rise_vec;
    logic [N_CH-1:0] fall_vec;
    logic [N_CH-1:0] rep_vec;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        // Shift the raw pin through the synchroniser chain.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in[gi]};
            end
        end

        // Debounce logic, per channel:
        //   - Any agreement between s and the level clears the count.
        //   - A mismatch held for DB_CYCLES cycles flips the level and fires
        //     the matching edge pulse.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            if (s == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_d = '0;
                level_d  = s;
                rise_d   = s;
                fall_d   = ~s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Register the debounce state and the edge pulses.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_cnt_q <= '0;
                level_q  <= RESET_LEVEL;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
            end
        end

        assign level_vec[gi] = level_q;
        assign rise_vec[gi]  = rise_q;
        assign fall_vec[gi]  = fall_q;

`ifdef BTN_REPEAT_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              armed_q, armed_d;
        logic              rep_q, rep_d;
        logic              rep_due;

        // Hold-timer behaviour:
        //   - The timer counts only while the level is already high.
        //   - The rise cycle itself therefore restarts it from zero.
        //   - The first repeat uses the delay.
        //   - Later repeats use the period.
        //   - A fall landing on a due repeat swallows that repeat.
        always_comb begin
            hold_d  = hold_q;
            armed_d = armed_q;
            rep_d   = 1'b0;
            rep_due = armed_q ? (hold_q == PERIOD_LAST) : (hold_q == DELAY_LAST);
            if (!level_q) begin
                hold_d  = '0;
                armed_d = 1'b0;
            end else if (rep_due) begin
                hold_d  = '0;
                armed_d = 1'b1;
                rep_d   = ~fall_d;
            end else begin
                hold_d  = hold_q + HOLD_W'(1);
            end
        end

        // Register the hold timer and the repeat pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_q  <= '0;
                armed_q <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                hold_q  <= hold_d;
                armed_q <= armed_d;
                rep_q   <= rep_d;
            end
        end

        assign rep_vec[gi] = rep_q;
`else
        assign rep_vec[gi] = 1'b0;
`endif
    end

    assign bus.btn_level  = level_vec;
    assign bus.btn_rise   = rise_vec;
    assign bus.btn_fall   = fall_vec;
    assign bus.btn_repeat = rep_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner.
// Configuration: DB_CYCLES=4, SYNC_STAGES=2, N_CH=2, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Timing: inputs change 1ns after a rising edge, and outputs are sampled 1ns after
// later rising edges. Edge k is the k-th rising edge after an input change.
// A clean change therefore appears on edge 6 (2 synchroniser edges + 4 debounce edges).
module tb_btn_conditioner;
    localparam int N_CH = 2;
`ifdef BTN_REPEAT_EN
    localparam bit REP_BUILD = 1'b1;
`else
    localparam bit REP_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    btn_conditioner_if #(.N_CH(N_CH)) bus ();

    btn_conditioner #(
        .N_CH          (N_CH),
        .DB_CYCLES     (4),
        .SYNC_STAGES   (2),
        .RESET_LEVEL   (1'b0),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges and check level/rise/fall/repeat on each one.
    // The level switches from lv_a to lv_b at edge k_chg, and the pulses fire
    // only on that edge. k_chg = 0 means the level never changes.
    task automatic expect_edges(input string tag, input int n, input int k_chg,
                                input logic [1:0] lv_a, input logic [1:0] lv_b,
                                input logic [1:0] rise_b, input logic [1:0] fall_b);
        $display("txn %s: btn_in=%b, %0d edges, change at edge %0d", tag, bus.btn_in, n, k_chg);
        for (int k = 1; k <= n; k++) begin
            tick();
            check($sformatf("%s_e%0d_level", tag, k), bus.btn_level,
                  (k_chg > 0 && k >= k_chg) ? lv_b : lv_a);
            check($sformatf("%s_e%0d_rise", tag, k), bus.btn_rise,
                  (k == k_chg) ? rise_b : 2'b00);
            check($sformatf("%s_e%0d_fall", tag, k), bus.btn_fall,
                  (k == k_chg) ? fall_b : 2'b00);
            check($sformatf("%s_e%0d_repeat", tag, k), bus.btn_repeat, 2'b00);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},  bus.btn_level,  2'b00);
        check({tag, "_rise"},   bus.btn_rise,   2'b00);
        check({tag, "_fall"},   bus.btn_fall,   2'b00);
        check({tag, "_repeat"}, bus.btn_repeat, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] lv, rs, fl, rp;

        // Power-on reset.
        rst        = 1'b0;
        bus.btn_in = 2'b00;
        #2;
        check_all_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();

        // Both channels rise together.
        bus.btn_in = 2'b11;
        expect_edges("both_rise", 7, 6, 2'b00, 2'b11, 2'b11, 2'b00);

        // Asynchronous reset mid-cycle with the inputs held high.
        #3;
        rst = 1'b0;
        #1;
        $display("txn async_rst: rst low mid-cycle, btn_in=%b", bus.btn_in);
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_edges("rst_release", 5, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        check("rst_release_e6_level", bus.btn_level, 2'b11);
        tick();
        check("rst_release_e7_level", bus.btn_level, 2'b11);

        // Both fall together, then a clean press and release on channel 0.
        bus.btn_in = 2'b00;
        expect_edges("both_fall", 7, 6, 2'b11, 2'b00, 2'b00, 2'b11);
        bus.btn_in = 2'b01;
        expect_edges("press0", 7, 6, 2'b00, 2'b01, 2'b01, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("release0", 7, 6, 2'b01, 2'b00, 2'b00, 2'b01);

        // Glitch: high for DB_CYCLES-1 cycles produces no change.
        bus.btn_in = 2'b01;
        expect_edges("glitch_hi", 3, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("glitch_lo", 7, 0, 2'b00, 2'b00, 2'b00, 2'b00);

        // Bounce on channel 1: 1,0,1,0,1, then held high.
        bus.btn_in = 2'b10;
        expect_edges("bounce_a", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("bounce_b", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_in = 2'b10;
        expect_edges("bounce_c", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("bounce_d", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.btn_in = 2'b10;
        expect_edges("bounce_hold", 8, 6, 2'b00, 2'b10, 2'b10, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("bounce_rel", 7, 6, 2'b10, 2'b00, 2'b00, 2'b10);

        // Reset in the middle of a count: the count is lost and restarts after release.
        bus.btn_in = 2'b11;
        expect_edges("pre_rst_cnt", 4, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        #1;
        check_all_zero("mid_cnt_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_edges("post_rst_cnt", 7, 6, 2'b00, 2'b11, 2'b11, 2'b00);
        bus.btn_in = 2'b00;
        expect_edges("post_rst_fall", 7, 6, 2'b11, 2'b00, 2'b00, 2'b11);

        // Auto-repeat on channel 0.
        //   - Rise at edge 6.
        //   - Repeats at edges 16, 21, 26 and 31.
        //   - Release after edge 30 lands the fall on edge 36, where the due
        //     repeat is suppressed.
        $display("txn repeat: hold btn_in[0], release after edge 30");
        bus.btn_in = 2'b01;
        for (int e = 1; e <= 40; e++) begin
            tick();
            lv = (e >= 6 && e < 36) ? 2'b01 : 2'b00;
            rs = (e == 6) ? 2'b01 : 2'b00;
            fl = (e == 36) ? 2'b01 : 2'b00;
            rp = (REP_BUILD && e >= 16 && e <= 31 && ((e - 16) % 5) == 0) ? 2'b01 : 2'b00;
            check($sformatf("rep_e%0d_level", e),  bus.btn_level,  lv);
            check($sformatf("rep_e%0d_rise", e),   bus.btn_rise,   rs);
            check($sformatf("rep_e%0d_fall", e),   bus.btn_fall,   fl);
            check($sformatf("rep_e%0d_repeat", e), bus.btn_repeat, rp);
            if (e == 30) bus.btn_in = 2'b00;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
